// File: rtl/lx32_pkg.sv
// Shared LX32 writeback types: the buffered load entry and the write-port source select.
package lx32_pkg;

   localparam int LX32_XLEN = 32;

   typedef struct packed {
      logic [4:0]           rd;
      logic [LX32_XLEN-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LSU,
      WB_BYP
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; occupancy is kept separately from the
// pointers so that full and empty never alias. DEPTH must be a power of two.
module wb_fifo
   import lx32_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  wb_entry_t        wr_entry,
   output wb_entry_t        rd_entry,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign rd_entry = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto the single register-file write port, with a
// load FIFO and starvation counter. Optional same-cycle load bypass: WB_LSU_BYPASS_EN.
module writeback_arbiter
   import lx32_pkg::*;
#(
   parameter  int XLEN            = LX32_XLEN,
   parameter  int LOAD_FIFO_DEPTH = 4,
   parameter  int STARVE_LIMIT    = 4,
   localparam int CNT_W           = $clog2(LOAD_FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [4:0]       alu_rd,
   input  logic [XLEN-1:0]  alu_data,
   input  logic             lsu_valid,
   output logic             lsu_ready,
   input  logic [4:0]       lsu_rd,
   input  logic [XLEN-1:0]  lsu_data,
   output logic             rf_we,
   output logic [4:0]       rf_addr_rd,
   output logic [XLEN-1:0]  rf_data_rd,
   output logic             lsu_pending,
   output logic [CNT_W-1:0] pending_count
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            force_lsu;
   logic [SC_W-1:0] starve_cnt;
   wb_entry_t       head;
   wb_entry_t       push_entry;
   wb_src_e         src;

   assign push_entry  = '{rd: lsu_rd, data: lsu_data};
   assign lsu_ready   = !fifo_full;
   assign lsu_pending = !fifo_empty;
   assign force_lsu   = !fifo_empty && (starve_cnt == SC_W'(STARVE_LIMIT));
   assign alu_ready   = !force_lsu;
   assign pop         = (src == WB_LSU);
   // x0 loads are accepted but dropped; bypassed loads never enter the FIFO.
   assign push        = lsu_valid && lsu_ready && (lsu_rd != 5'd0) && (src != WB_BYP);

   always_comb begin
      src = WB_NONE;
      if (!rst_n)
         src = WB_NONE;
      else if (force_lsu)
         src = WB_LSU;
      else if (alu_valid && (alu_rd != 5'd0))
         src = WB_ALU;
      else if (!fifo_empty)
         src = WB_LSU;
`ifdef WB_LSU_BYPASS_EN
      else if (!alu_valid && lsu_valid && (lsu_rd != 5'd0))
         src = WB_BYP;
`endif
   end

   always_comb begin
      rf_we      = (src != WB_NONE);
      rf_addr_rd = '0;
      rf_data_rd = '0;
      case (src)
         WB_ALU: begin
            rf_addr_rd = alu_rd;
            rf_data_rd = alu_data;
         end
         WB_LSU: begin
            rf_addr_rd = head.rd;
            rf_data_rd = head.data;
         end
`ifdef WB_LSU_BYPASS_EN
         WB_BYP: begin
            rf_addr_rd = lsu_rd;
            rf_data_rd = lsu_data;
         end
`endif
         default: ;
      endcase
   end

   // Counts ALU wins while loads wait; any pop or an empty FIFO restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (pop || fifo_empty)
         starve_cnt <= '0;
      else if ((src == WB_ALU) && (starve_cnt != SC_W'(STARVE_LIMIT)))
         starve_cnt <= starve_cnt + SC_W'(1);
   end

   wb_fifo #(
      .DEPTH (LOAD_FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .wr_entry (push_entry),
      .rd_entry (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (pending_count)
   );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_writeback_arbiter;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int LIMIT = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            rf_we;
   logic [4:0]      rf_addr_rd;
   logic [XLEN-1:0] rf_data_rd;
   logic            lsu_pending;
   logic [2:0]      pending_count;

   logic [XLEN-1:0] rf_mem [32] = '{default: '0};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   writeback_arbiter #(
      .XLEN            (XLEN),
      .LOAD_FIFO_DEPTH (DEPTH),
      .STARVE_LIMIT    (LIMIT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .lsu_valid     (lsu_valid),
      .lsu_ready     (lsu_ready),
      .lsu_rd        (lsu_rd),
      .lsu_data      (lsu_data),
      .rf_we         (rf_we),
      .rf_addr_rd    (rf_addr_rd),
      .rf_data_rd    (rf_data_rd),
      .lsu_pending   (lsu_pending),
      .pending_count (pending_count)
   );

   // Plain register file with no x0 hardwiring, so a leaked x0 write shows up.
   always @(posedge clk) begin
      if (rf_we) rf_mem[rf_addr_rd] <= rf_data_rd;
   end

   typedef struct {
      logic            av;
      logic [4:0]      ar;
      logic [XLEN-1:0] ad;
      logic            lv;
      logic [4:0]      lr;
      logic [XLEN-1:0] ld;
      logic            we;
      logic [4:0]      wa;
      logic [XLEN-1:0] wd;
      logic            ardy;
      logic [2:0]      cnt;
   } vec_t;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] d;
   } ent_t;

   vec_t vt [7];
   ent_t mq [$];
   int   msc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ld);
      alu_valid = av;
      alu_rd    = ar;
      alu_data  = ad;
      lsu_valid = lv;
      lsu_rd    = lr;
      lsu_data  = ld;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string name, input logic [4:0] a, input logic [XLEN-1:0] d);
      chk({name, "_we"}, 64'(rf_we), 64'd1);
      chk({name, "_addr"}, 64'(rf_addr_rd), 64'(a));
      chk({name, "_data"}, 64'(rf_data_rd), 64'(d));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state; an ALU request held during reset must not reach the port.
      rst_n = 1'b0;
      drive(1'b1, 5'd5, 32'h1111_2222, 1'b1, 5'd6, 32'h3);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("rst_we", 64'(rf_we), 64'd0);
         chk("rst_alu_ready", 64'(alu_ready), 64'd1);
         chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
         chk("rst_count", 64'(pending_count), 64'd0);
         step();
      end
      rst_n = 1'b1;
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      settle();
      chk("post_rst_we", 64'(rf_we), 64'd0);
      chk("post_rst_alu_ready", 64'(alu_ready), 64'd1);
      chk("post_rst_lsu_ready", 64'(lsu_ready), 64'd1);
      chk("post_rst_count", 64'(pending_count), 64'd0);
      chk("post_rst_pending", 64'(lsu_pending), 64'd0);
      step();

      // Vector table: ALU write, x0 filters, FIFO ordering behind the ALU.
      vt[0] = '{1'b1, 5'd5, 32'hABCD_1234, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hABCD_1234, 1'b1, 3'd0};
      vt[1] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,         1'b1, 3'd0};
      vt[2] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'h1,  1'b0, 5'd0, 32'h0,         1'b1, 3'd0};
      vt[3] = '{1'b1, 5'd3, 32'h33,        1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33,        1'b1, 3'd1};
      vt[4] = '{1'b1, 5'd0, 32'h99,        1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44,        1'b1, 3'd1};
      vt[5] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h66,        1'b1, 3'd0};
      vt[6] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,         1'b1, 3'd0};
      for (int i = 0; i < 7; i++) begin
         drive(vt[i].av, vt[i].ar, vt[i].ad, vt[i].lv, vt[i].lr, vt[i].ld);
         settle();
         chk($sformatf("vec%0d_we", i), 64'(rf_we), 64'(vt[i].we));
         if (vt[i].we) begin
            chk($sformatf("vec%0d_addr", i), 64'(rf_addr_rd), 64'(vt[i].wa));
            chk($sformatf("vec%0d_data", i), 64'(rf_data_rd), 64'(vt[i].wd));
         end
         chk($sformatf("vec%0d_alu_ready", i), 64'(alu_ready), 64'(vt[i].ardy));
         chk($sformatf("vec%0d_lsu_ready", i), 64'(lsu_ready), 64'd1);
         step();
         chk($sformatf("vec%0d_count", i), 64'(pending_count), 64'(vt[i].cnt));
      end
      chk("rf_x5", 64'(rf_mem[5]), 64'hABCD_1234);
      chk("rf_x0", 64'(rf_mem[0]), 64'd0);

      // Starvation: load pushed while the ALU sends a filtered x0, then ALU streams.
      drive(1'b1, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
      settle();
      chk("starve_push_we", 64'(rf_we), 64'd0);
      step();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, '0);
         settle();
         chk($sformatf("starve_alu%0d_ready", i), 64'(alu_ready), 64'd1);
         chk_wr($sformatf("starve_alu%0d", i), 5'(i), 32'h100 + 32'(i));
         step();
      end
      drive(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, '0);
      settle();
      chk("starve_force_alu_ready", 64'(alu_ready), 64'd0);
      chk_wr("starve_force", 5'd7, 32'h11);
      step();
      settle();
      chk("starve_resume_alu_ready", 64'(alu_ready), 64'd1);
      chk_wr("starve_resume", 5'd5, 32'h105);
      step();

      // Full FIFO behind a busy ALU, then drain in push order.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(i + 1), 32'h300 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
         settle();
         chk($sformatf("full_push%0d_lsu_ready", i), 64'(lsu_ready), 64'd1);
         chk_wr($sformatf("full_alu%0d", i), 5'(i + 1), 32'h300 + 32'(i));
         step();
         chk($sformatf("full_push%0d_count", i), 64'(pending_count), 64'(i + 1));
      end
      drive(1'b0, 5'd0, '0, 1'b1, 5'd24, 32'h2FF);
      settle();
      chk("full_lsu_ready", 64'(lsu_ready), 64'd0);
      chk("full_count", 64'(pending_count), 64'd4);
      chk_wr("full_drain0", 5'd20, 32'h200);
      step();
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      for (int i = 1; i < 4; i++) begin
         settle();
         chk_wr($sformatf("full_drain%0d", i), 5'(20 + i), 32'h200 + 32'(i));
         step();
      end
      settle();
      chk("full_drained_we", 64'(rf_we), 64'd0);
      chk("full_drained_count", 64'(pending_count), 64'd0);
      step();

      // Asynchronous reset with two loads pending discards them.
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0);
      step();
      drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB0);
      step();
      chk("areset_pre_count", 64'(pending_count), 64'd2);
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("areset_count", 64'(pending_count), 64'd0);
      chk("areset_pending", 64'(lsu_pending), 64'd0);
      chk("areset_we", 64'(rf_we), 64'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk($sformatf("areset_after%0d_we", i), 64'(rf_we), 64'd0);
         step();
      end
      chk("areset_x10", 64'(rf_mem[10]), 64'd0);
      chk("areset_x11", 64'(rf_mem[11]), 64'd0);

      // Load into an empty FIFO with the ALU idle: bypass or one-cycle latency.
      drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h55);
      settle();
`ifdef WB_LSU_BYPASS_EN
      chk_wr("bypass_same_cycle", 5'd9, 32'h55);
      step();
      chk("bypass_count", 64'(pending_count), 64'd0);
`else
      chk("nobypass_same_cycle_we", 64'(rf_we), 64'd0);
      step();
      chk("nobypass_count", 64'(pending_count), 64'd1);
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      settle();
      chk_wr("nobypass_next_cycle", 5'd9, 32'h55);
      step();
`endif

      // Randomized run against the reference model, from a fresh reset.
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mq.delete();
      msc = 0;
      for (int n = 0; n < 3000; n++) begin
         logic            av, lv, m_lr, m_force, m_we, do_pop, do_byp, alu_wr;
         logic [4:0]      ar, lr, m_wa;
         logic [XLEN-1:0] ad, ld, m_wd;
         int              sz;
         av = ($urandom_range(0, 99) < 70);
         lv = ($urandom_range(0, 99) < 45);
         ar = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         lr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ad = $urandom;
         ld = $urandom;
         drive(av, ar, ad, lv, lr, ld);
         settle();

         sz      = mq.size();
         m_lr    = (sz < DEPTH);
         m_force = (sz > 0) && (msc == LIMIT);
         m_we    = 1'b0;
         m_wa    = '0;
         m_wd    = '0;
         do_pop  = 1'b0;
         do_byp  = 1'b0;
         alu_wr  = 1'b0;
         if (m_force) begin
            m_we = 1'b1; m_wa = mq[0].rd; m_wd = mq[0].d; do_pop = 1'b1;
         end else if (av && ar != 0) begin
            m_we = 1'b1; m_wa = ar; m_wd = ad; alu_wr = 1'b1;
         end else if (sz > 0) begin
            m_we = 1'b1; m_wa = mq[0].rd; m_wd = mq[0].d; do_pop = 1'b1;
         end
`ifdef WB_LSU_BYPASS_EN
         else if (!av && lv && lr != 0) begin
            m_we = 1'b1; m_wa = lr; m_wd = ld; do_byp = 1'b1;
         end
`endif
         chk("rnd_we", 64'(rf_we), 64'(m_we));
         if (m_we) begin
            chk("rnd_addr", 64'(rf_addr_rd), 64'(m_wa));
            chk("rnd_data", 64'(rf_data_rd), 64'(m_wd));
         end
         chk("rnd_alu_ready", 64'(alu_ready), 64'(!m_force));
         chk("rnd_lsu_ready", 64'(lsu_ready), 64'(m_lr));
         chk("rnd_count", 64'(pending_count), 64'(sz));
         chk("rnd_pending", 64'(lsu_pending), 64'(sz > 0));

         if (do_pop) void'(mq.pop_front());
         if (lv && m_lr && lr != 0 && !do_byp) mq.push_back('{rd: lr, d: ld});
         if (do_pop || sz == 0) msc = 0;
         else if (alu_wr && msc < LIMIT) msc = msc + 1;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
